// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : IF/MEM request ports and unified-memory handshake bundle.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;
    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_stall;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;
    logic              timeout_err;

    // master: the arbiter itself; slave: pipeline stages plus memory
    modport master (
        input  if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
        output m_req, m_we, m_addr, m_wdata, timeout_err
    );

    modport slave (
        output if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
        input  m_req, m_we, m_addr, m_wdata, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Data-over-instruction arbiter for a shared variable-latency
//            memory, with req/ack handshake and a watchdog abort.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_ready;
    logic              r_d_ready;
    logic              r_timeout_err;
    logic [7:0]        w_cnt_next;

    assign w_cnt_next = r_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_m_req       <= 1'b0;
            r_m_we        <= 1'b0;
            r_m_addr      <= '0;
            r_m_wdata     <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_if_ready    <= 1'b0;
            r_d_ready     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.d_ren | bus.d_wen) begin
                        r_state   <= S_DATA;
                        r_m_req   <= 1'b1;
                        r_m_we    <= bus.d_wen;
                        r_m_addr  <= bus.d_addr;
                        r_m_wdata <= bus.d_wdata;
                        r_cnt     <= '0;
                    end else if (bus.if_req) begin
                        r_state   <= S_INST;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= bus.if_addr;
                        r_m_wdata <= bus.d_wdata;
                        r_cnt     <= '0;
                    end
                end
                S_DATA, S_INST: begin
                    // An ack arriving on the watchdog's last cycle still counts as success
                    if (bus.m_ack) begin
                        r_m_req <= 1'b0;
                        r_state <= S_DONE;
                        if (r_state == S_DATA) begin
                            r_d_ready <= 1'b1;
                            if (!r_m_we) begin
                                r_d_rdata <= bus.m_rdata;
                            end
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= bus.m_rdata;
                        end
                    end else if (w_cnt_next == c_timeout) begin
                        r_m_req       <= 1'b0;
                        r_state       <= S_DONE;
                        r_timeout_err <= 1'b1;
                        r_cnt         <= w_cnt_next;
                        if (r_state == S_DATA) begin
                            r_d_ready <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_req       = r_m_req;
    assign bus.m_we        = r_m_we;
    assign bus.m_addr      = r_m_addr;
    assign bus.m_wdata     = r_m_wdata;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.if_ready    = r_if_ready;
    assign bus.d_ready     = r_d_ready;
    assign bus.timeout_err = r_timeout_err;

    // Combinational so the controller can freeze stages in the completing cycle's peer
    assign bus.if_stall = bus.if_req & ~r_if_ready;
    assign bus.d_stall  = (bus.d_ren | bus.d_wen) & ~r_d_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first m_req cycle; acks after dly extra cycles, returns in DONE
    task automatic serve(input int dly, input logic [31:0] rd, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i <= dly; i++) begin
            chk("m_req_hold", 32'(b1.m_req), 32'd1);
            chk("m_we", 32'(b1.m_we), 32'(we));
            chk("m_addr", b1.m_addr, addr);
            if (we) chk("m_wdata", b1.m_wdata, wd);
            if (i == dly) begin
                b1.m_ack   = 1'b1;
                b1.m_rdata = rd;
            end
            tick();
            b1.m_ack   = 1'b0;
            b1.m_rdata = '0;
        end
    endtask

    task automatic clear_inputs();
        b1.if_req = 0; b1.if_addr = '0; b1.d_ren = 0; b1.d_wen = 0;
        b1.d_addr = '0; b1.d_wdata = '0; b1.m_rdata = '0; b1.m_ack = 0;
        b2.if_req = 0; b2.if_addr = '0; b2.d_ren = 0; b2.d_wen = 0;
        b2.d_addr = '0; b2.d_wdata = '0; b2.m_rdata = '0; b2.m_ack = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();

        chk("rst_m_req", 32'(b1.m_req), 0);
        chk("rst_m_we", 32'(b1.m_we), 0);
        chk("rst_m_addr", b1.m_addr, 0);
        chk("rst_m_wdata", b1.m_wdata, 0);
        chk("rst_if_rdata", b1.if_rdata, 0);
        chk("rst_d_rdata", b1.d_rdata, 0);
        chk("rst_ready", {30'd0, b1.if_ready, b1.d_ready}, 0);
        chk("rst_terr", 32'(b1.timeout_err), 0);
        chk("rst_to_terr", 32'(b2.timeout_err), 0);
        rst_n = 1'b1;
        tick();

        // single fetch
        b1.if_req = 1; b1.if_addr = 32'h0000_0040;
        #1 chk("fetch_if_stall_wait", 32'(b1.if_stall), 1);
        tick();
        serve(1, 32'h2008_0005, 1'b0, 32'h40, 32'h0);
        chk("fetch_if_ready", 32'(b1.if_ready), 1);
        chk("fetch_if_rdata", b1.if_rdata, 32'h2008_0005);
        chk("fetch_if_stall_done", 32'(b1.if_stall), 0);
        chk("fetch_m_req_drop", 32'(b1.m_req), 0);
        b1.if_req = 0;
        tick();
        chk("fetch_ready_single", 32'(b1.if_ready), 0);
        tick();

        // collision: data wins, fetch follows after DONE and IDLE
        b1.if_req = 1; b1.if_addr = 32'h80;
        b1.d_ren = 1; b1.d_addr = 32'h100;
        tick();
        serve(0, 32'h1111_2222, 1'b0, 32'h100, 32'h0);
        chk("coll_d_ready", 32'(b1.d_ready), 1);
        chk("coll_if_ready_low", 32'(b1.if_ready), 0);
        chk("coll_d_rdata", b1.d_rdata, 32'h1111_2222);
        chk("coll_d_stall", 32'(b1.d_stall), 0);
        chk("coll_if_stall", 32'(b1.if_stall), 1);
        b1.d_ren = 0;
        tick();
        chk("coll_idle_m_req", 32'(b1.m_req), 0);
        chk("coll_idle_ready", {30'd0, b1.if_ready, b1.d_ready}, 0);
        tick();
        serve(0, 32'h3333_4444, 1'b0, 32'h80, 32'h0);
        chk("coll_if_ready", 32'(b1.if_ready), 1);
        chk("coll_if_rdata", b1.if_rdata, 32'h3333_4444);
        chk("coll_d_ready_low", 32'(b1.d_ready), 0);
        b1.if_req = 0;
        tick();

        // store held five cycles
        b1.d_wen = 1; b1.d_addr = 32'h200; b1.d_wdata = 32'hDEAD_BEEF;
        #1 chk("st_d_stall", 32'(b1.d_stall), 1);
        tick();
        serve(4, 32'h5555_5555, 1'b1, 32'h200, 32'hDEAD_BEEF);
        chk("st_d_ready", 32'(b1.d_ready), 1);
        chk("st_d_rdata_keep", b1.d_rdata, 32'h1111_2222);
        b1.d_wen = 0; b1.d_wdata = '0;
        tick();
        chk("st_ready_single", 32'(b1.d_ready), 0);

        // ren and wen together behave as a store
        b1.d_ren = 1; b1.d_wen = 1; b1.d_addr = 32'h204; b1.d_wdata = 32'h0123_4567;
        tick();
        serve(0, 32'h9999_9999, 1'b1, 32'h204, 32'h0123_4567);
        chk("rw_d_ready", 32'(b1.d_ready), 1);
        chk("rw_d_rdata_keep", b1.d_rdata, 32'h1111_2222);
        b1.d_ren = 0; b1.d_wen = 0; b1.d_wdata = '0;
        tick();

        // stray ack in IDLE
        b1.m_ack = 1; b1.m_rdata = 32'hFFFF_FFFF;
        tick();
        b1.m_ack = 0; b1.m_rdata = '0;
        chk("stray_ready", {30'd0, b1.if_ready, b1.d_ready}, 0);
        chk("stray_m_req", 32'(b1.m_req), 0);
        tick();
        chk("stray_d_rdata", b1.d_rdata, 32'h1111_2222);
        chk("stray_if_rdata", b1.if_rdata, 32'h3333_4444);

        // asynchronous reset mid-access
        b1.d_ren = 1; b1.d_addr = 32'h300;
        tick();
        chk("rma_m_req_up", 32'(b1.m_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rma_m_req_drop", 32'(b1.m_req), 0);
        chk("rma_m_addr", b1.m_addr, 0);
        chk("rma_d_rdata", b1.d_rdata, 0);
        chk("rma_if_rdata", b1.if_rdata, 0);
        b1.d_ren = 0;
        tick();
        chk("rma_no_ready", 32'(b1.d_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("rma_after_ready", 32'(b1.d_ready), 0);
        chk("rma_after_m_req", 32'(b1.m_req), 0);
        b1.d_ren = 1; b1.d_addr = 32'h304;
        tick();
        serve(0, 32'hCAFE_F00D, 1'b0, 32'h304, 32'h0);
        chk("rma_next_ready", 32'(b1.d_ready), 1);
        chk("rma_next_rdata", b1.d_rdata, 32'hCAFE_F00D);
        b1.d_ren = 0;
        tick();

        // TIMEOUT=4: ack on the last allowed cycle wins
        b2.d_ren = 1; b2.d_addr = 32'h400;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("race_m_req", 32'(b2.m_req), 1);
            if (i == 3) begin
                b2.m_ack = 1; b2.m_rdata = 32'hABCD_0123;
            end
            tick();
            b2.m_ack = 0; b2.m_rdata = '0;
        end
        chk("race_d_ready", 32'(b2.d_ready), 1);
        chk("race_d_rdata", b2.d_rdata, 32'hABCD_0123);
        chk("race_terr", 32'(b2.timeout_err), 0);
        b2.d_ren = 0;
        tick();
        tick();

        // TIMEOUT=4: no ack, abort after four request cycles
        b2.d_ren = 1; b2.d_addr = 32'h404;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_m_req", 32'(b2.m_req), 1);
            tick();
        end
        chk("to_m_req_drop", 32'(b2.m_req), 0);
        chk("to_d_ready", 32'(b2.d_ready), 1);
        chk("to_d_rdata_zero", b2.d_rdata, 0);
        chk("to_terr", 32'(b2.timeout_err), 1);
        b2.d_ren = 0;
        repeat (3) tick();
        chk("to_terr_sticky", 32'(b2.timeout_err), 1);
        chk("to_ready_low", 32'(b2.d_ready), 0);
        chk("main_terr_clear", 32'(b1.timeout_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
